// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: ALU control codes (also used by the ALU),
// opcodes, source-A select encodings and the decoded-entry record.
package decode_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SLTS = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_EQ   = 5'b11000;
  localparam logic [4:0] ALU_NE   = 5'b11001;
  localparam logic [4:0] ALU_LTS  = 5'b11100;
  localparam logic [4:0] ALU_GES  = 5'b11101;
  localparam logic [4:0] ALU_LTU  = 5'b11110;
  localparam logic [4:0] ALU_GEU  = 5'b11111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  typedef struct packed {
    logic [4:0]  alu;
    logic [1:0]  srca;
    logic        srcb;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we_reg;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake bus of the decode stage.
interface decode_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] instr_i;
  logic [XLEN-1:0] pc_i;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      Upr_ALU;
  logic [1:0]      srcA_sel;
  logic            srcB_sel;
  logic [XLEN-1:0] imm_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [4:0]      rd_o;
  logic [XLEN-1:0] pc_o;
  logic            we_reg;
  logic            mem_req;
  logic            mem_we;
  logic [2:0]      mem_size;
  logic            branch;
  logic            jal;
  logic            jalr;
  logic            illegal_o;

  modport master (
    output in_valid, instr_i, pc_i, out_ready,
    input  in_ready, out_valid, Upr_ALU, srcA_sel, srcB_sel, imm_o,
           rs1_o, rs2_o, rd_o, pc_o, we_reg, mem_req, mem_we, mem_size,
           branch, jal, jalr, illegal_o
  );

  modport slave (
    input  in_valid, instr_i, pc_i, out_ready,
    output in_ready, out_valid, Upr_ALU, srcA_sel, srcB_sel, imm_o,
           rs1_o, rs2_o, rd_o, pc_o, we_reg, mem_req, mem_we, mem_size,
           branch, jal, jalr, illegal_o
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder: instruction word to ALU code, selects,
// immediate, register indices and control-flow / memory class.
module instr_decoder
  import decode_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec      = '0;
        dec.alu  = ALU_ADD;
        dec.srca = SRCA_RS1;
        dec.rs1  = instr[19:15];
        dec.rs2  = instr[24:20];
        dec.rd   = instr[11:7];
        unique case (opc)
            OPC_OP: begin
                dec.alu     = {1'b0, instr[30], f3};
                dec.we_reg  = 1'b1;
                dec.illegal = !((f7 == 7'b0000000) ||
                                (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_OPIMM: begin
                dec.alu    = {1'b0, (f3 == 3'b101) & instr[30], f3};
                dec.srcb   = 1'b1;
                dec.we_reg = 1'b1;
                dec.imm    = imm_i;
                // Shifts carry a zero-extended shamt; funct7 only selects SRLI/SRAI.
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.imm     = {27'b0, instr[24:20]};
                    dec.illegal = (f3 == 3'b001) ? (f7 != 7'b0000000)
                                                 : !(f7 == 7'b0000000 || f7 == 7'b0100000);
                end
            end
            OPC_LUI: begin
                dec.srca   = SRCA_ZERO;
                dec.srcb   = 1'b1;
                dec.imm    = imm_u;
                dec.we_reg = 1'b1;
            end
            OPC_AUIPC: begin
                dec.srca   = SRCA_PC;
                dec.srcb   = 1'b1;
                dec.imm    = imm_u;
                dec.we_reg = 1'b1;
            end
            OPC_LOAD: begin
                dec.srcb     = 1'b1;
                dec.imm      = imm_i;
                dec.mem_req  = 1'b1;
                dec.we_reg   = 1'b1;
                dec.mem_size = f3;
                dec.illegal  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                dec.srcb     = 1'b1;
                dec.imm      = imm_s;
                dec.mem_req  = 1'b1;
                dec.mem_we   = 1'b1;
                dec.mem_size = f3;
                dec.illegal  = f3[2] || (f3 == 3'b011);
            end
            OPC_BRANCH: begin
                dec.alu     = {2'b11, f3};
                dec.imm     = imm_b;
                dec.branch  = 1'b1;
                dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_JAL: begin
                dec.srca   = SRCA_PC;
                dec.srcb   = 1'b1;
                dec.imm    = imm_j;
                dec.jal    = 1'b1;
                dec.we_reg = 1'b1;
            end
            OPC_JALR: begin
                dec.srcb    = 1'b1;
                dec.imm     = imm_i;
                dec.jalr    = 1'b1;
                dec.we_reg  = 1'b1;
                dec.illegal = (f3 != 3'b000);
            end
            default: dec.illegal = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) dec.illegal = 1'b1;
        // Illegal entries travel down the pipe but must not cause any side effect.
        if (dec.illegal) begin
            dec.alu     = ALU_ADD;
            dec.we_reg  = 1'b0;
            dec.mem_req = 1'b0;
            dec.mem_we  = 1'b0;
            dec.branch  = 1'b0;
            dec.jal     = 1'b0;
            dec.jalr    = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: one-entry output register with
// valid/ready handshake, backpressure and flush.
module decode_stage
  import decode_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit RESET_ILLEGAL = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    decode_if.slave  bus
);

    dec_t            dec_p0;
    dec_t            dec_p1;
    logic [XLEN-1:0] pc_p1;
    logic            vld_p1;
    logic            load_p0;

    instr_decoder u_dec (
        .instr (bus.instr_i),
        .dec   (dec_p0)
    );

    assign bus.in_ready = !vld_p1 | bus.out_ready;
    assign load_p0      = bus.in_valid & bus.in_ready;

    // p0 -> p1: decoded entry register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            dec_p1 <= '0;
            pc_p1  <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (load_p0) begin
            vld_p1 <= 1'b1;
            dec_p1 <= dec_p0;
            pc_p1  <= bus.pc_i;
        end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.Upr_ALU   = dec_p1.alu;
    assign bus.srcA_sel  = dec_p1.srca;
    assign bus.srcB_sel  = dec_p1.srcb;
    assign bus.imm_o     = dec_p1.imm;
    assign bus.rs1_o     = dec_p1.rs1;
    assign bus.rs2_o     = dec_p1.rs2;
    assign bus.rd_o      = dec_p1.rd;
    assign bus.pc_o      = pc_p1;
    assign bus.we_reg    = dec_p1.we_reg;
    assign bus.mem_req   = dec_p1.mem_req;
    assign bus.mem_we    = dec_p1.mem_we;
    assign bus.mem_size  = dec_p1.mem_size;
    assign bus.branch    = dec_p1.branch;
    assign bus.jal       = dec_p1.jal;
    assign bus.jalr      = dec_p1.jalr;
    assign bus.illegal_o = vld_p1 ? dec_p1.illegal : RESET_ILLEGAL;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, backpressure, flush, reset.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  decode_if #(.XLEN(32)) dif ();

  decode_stage #(.XLEN(32), .RESET_ILLEGAL(1'b0)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    dif.in_valid = 1'b1;
    dif.instr_i  = instr;
    dif.pc_i     = pc;
    step();
  endtask

  task automatic chk_no_side_effects(input string tag);
    chk({tag, "_ill"}, 32'(dif.illegal_o), 32'd1);
    chk({tag, "_vld"}, 32'(dif.out_valid), 32'd1);
    chk({tag, "_upr"}, 32'(dif.Upr_ALU), 32'd0);
    chk({tag, "_en"},  32'({dif.we_reg, dif.mem_req, dif.mem_we,
                            dif.branch, dif.jal, dif.jalr}), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    dif.in_valid  = 1'b0;
    dif.instr_i   = '0;
    dif.pc_i      = '0;
    dif.out_ready = 1'b1;
    step();
    step();
    chk("rst_vld",  32'(dif.out_valid), 32'd0);
    chk("rst_upr",  32'(dif.Upr_ALU), 32'd0);
    chk("rst_imm",  dif.imm_o, 32'd0);
    chk("rst_we",   32'(dif.we_reg), 32'd0);
    chk("rst_ill",  32'(dif.illegal_o), 32'd0);
    chk("rst_rdy",  32'(dif.in_ready), 32'd1);
    rst = 1'b0;

    // add x3,x1,x2
    send(32'h002081B3, 32'h0000_0010);
    chk("add_vld",  32'(dif.out_valid), 32'd1);
    chk("add_upr",  32'(dif.Upr_ALU), 32'h00);
    chk("add_srcb", 32'(dif.srcB_sel), 32'd0);
    chk("add_idx",  32'({dif.rd_o, dif.rs1_o, dif.rs2_o}), 32'({5'd3, 5'd1, 5'd2}));
    chk("add_we",   32'(dif.we_reg), 32'd1);
    chk("add_pc",   dif.pc_o, 32'h0000_0010);
    send(32'h402081B3, 32'h0000_0014);
    chk("sub_upr",  32'(dif.Upr_ALU), 32'h08);
    chk("sub_vld",  32'(dif.out_valid), 32'd1);
    // srai x5,x6,3
    send(32'h40335293, 32'h0000_0018);
    chk("srai_upr", 32'(dif.Upr_ALU), 32'h0D);
    chk("srai_imm", dif.imm_o, 32'd3);
    chk("srai_b",   32'(dif.srcB_sel), 32'd1);
    chk("srai_rd",  32'(dif.rd_o), 32'd5);
    // beq x1,x2,-4
    send(32'hFE208EE3, 32'h0000_001C);
    chk("beq_upr",  32'(dif.Upr_ALU), 32'h18);
    chk("beq_br",   32'(dif.branch), 32'd1);
    chk("beq_imm",  dif.imm_o, 32'hFFFF_FFFC);
    chk("beq_we",   32'(dif.we_reg), 32'd0);
    chk("beq_b",    32'(dif.srcB_sel), 32'd0);
    send(32'hFFFFFFFF, 32'h0000_0020);
    chk_no_side_effects("allones");
    send(32'h0000A063, 32'h0000_0024);
    chk_no_side_effects("br010");
    // sw x2,8(x1)
    send(32'h0020A423, 32'h0000_0028);
    chk("sw_mem",   32'({dif.mem_req, dif.mem_we, dif.we_reg}), 32'b110);
    chk("sw_imm",   dif.imm_o, 32'd8);
    chk("sw_size",  32'(dif.mem_size), 32'd2);
    chk("sw_ill",   32'(dif.illegal_o), 32'd0);
    // lui x1,0x12345
    send(32'h123450B7, 32'h0000_002C);
    chk("lui_imm",  dif.imm_o, 32'h1234_5000);
    chk("lui_srca", 32'(dif.srcA_sel), 32'b10);
    chk("lui_upr",  32'(dif.Upr_ALU), 32'h00);
    dif.in_valid = 1'b0;
    step();
    chk("drain_vld", 32'(dif.out_valid), 32'd0);
    chk("drain_imm", dif.imm_o, 32'h1234_5000);
    chk("drain_pc",  dif.pc_o, 32'h0000_002C);

    // backpressure: A held for 3 cycles while B waits
    send(32'h002081B3, 32'h0000_0100);
    dif.out_ready = 1'b0;
    dif.instr_i   = 32'h402081B3;
    dif.pc_i      = 32'h0000_0104;
    #1;
    chk("bp_rdy0", 32'(dif.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_vld",  32'(dif.out_valid), 32'd1);
      chk("bp_pc",   dif.pc_o, 32'h0000_0100);
      chk("bp_upr",  32'(dif.Upr_ALU), 32'h00);
      chk("bp_rdy",  32'(dif.in_ready), 32'd0);
    end
    dif.out_ready = 1'b1;
    #1;
    chk("bp_rdy1", 32'(dif.in_ready), 32'd1);
    step();
    chk("bp_b_pc",  dif.pc_o, 32'h0000_0104);
    chk("bp_b_upr", 32'(dif.Upr_ALU), 32'h08);
    chk("bp_b_vld", 32'(dif.out_valid), 32'd1);
    dif.in_valid = 1'b0;
    step();
    chk("bp_end",   32'(dif.out_valid), 32'd0);

    // flush with held entry and a same-cycle transfer
    send(32'h002081B3, 32'h0000_0200);
    flush = 1'b1;
    dif.instr_i = 32'h402081B3;
    dif.pc_i    = 32'h0000_0204;
    #1;
    chk("fl_rdy",  32'(dif.in_ready), 32'd1);
    step();
    flush = 1'b0;
    dif.in_valid = 1'b0;
    chk("fl_vld",  32'(dif.out_valid), 32'd0);
    chk("fl_pc",   dif.pc_o, 32'h0000_0200);
    step();
    chk("fl_vld2", 32'(dif.out_valid), 32'd0);
    send(32'h40335293, 32'h0000_0300);
    chk("fl_next", dif.pc_o, 32'h0000_0300);
    chk("fl_nvld", 32'(dif.out_valid), 32'd1);

    // reset mid-stream
    dif.instr_i = 32'hFE208EE3;
    dif.pc_i    = 32'h0000_0304;
    rst = 1'b1;
    step();
    chk("mr_vld",  32'(dif.out_valid), 32'd0);
    chk("mr_upr",  32'(dif.Upr_ALU), 32'd0);
    chk("mr_imm",  dif.imm_o, 32'd0);
    chk("mr_pc",   dif.pc_o, 32'd0);
    chk("mr_ctl",  32'({dif.branch, dif.we_reg, dif.srcB_sel, dif.srcA_sel, dif.rd_o}), 32'd0);
    rst = 1'b0;
    dif.in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
